pipe_hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage ARM core. It owns the `freeze`/`flush` controls of the IF/ID pipeline register and the bubble/hold controls of the later stage registers. It combines three inputs into one consistent set of per-stage controls:
- data-hazard detection, forwarding-aware;
- taken-branch flush;
- a multi-cycle SRAM wait state machine with timeout.

It also keeps a saturating stall-cycle counter for performance debug.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 29 ++
 rtl/pipe_hazard_ctrl_if.sv | 39 +++
 rtl/pipe_hazard_ctrl_hazard_detect.sv | 35 +++
 rtl/pipe_hazard_ctrl.sv | 114 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: register index
// width, controller state encoding and the per-stage control bundle.
package pipe_hazard_ctrl_pkg;

  localparam int REG_W   = 4;
  localparam int STALL_W = 32;

  typedef logic [REG_W-1:0] reg_idx_t;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

  typedef struct packed {
    logic if_freeze;
    logic if_flush;
    logic id_bubble;
    logic pipe_freeze;
  } stage_ctrl_t;

  // True when a write-back producer targets the given source register.
  function automatic logic writes_to(input logic wb_en, input reg_idx_t dest,
                                     input reg_idx_t src);
    return wb_en && (dest == src);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side bundle of the sequencing controller: hazard inputs, branch,
// SRAM handshake and the resulting per-stage controls.
interface pipe_hazard_ctrl_if;
  import pipe_hazard_ctrl_pkg::*;

  logic                id_valid;
  logic                two_src;
  reg_idx_t            src1;
  reg_idx_t            src2;
  logic                exe_wb_en;
  logic                exe_mem_r_en;
  reg_idx_t            exe_dest;
  logic                mem_wb_en;
  reg_idx_t            mem_dest;
  logic                fwd_en;
  logic                branch_taken;
  logic                mem_access;
  logic                sram_ready;

  logic                if_freeze;
  logic                if_flush;
  logic                id_bubble;
  logic                pipe_freeze;
  logic                mem_err;
  logic [STALL_W-1:0]  stall_cycles;

  modport master (
    output id_valid, two_src, src1, src2, exe_wb_en, exe_mem_r_en, exe_dest,
           mem_wb_en, mem_dest, fwd_en, branch_taken, mem_access, sram_ready,
    input  if_freeze, if_flush, id_bubble, pipe_freeze, mem_err, stall_cycles
  );

  modport slave (
    input  id_valid, two_src, src1, src2, exe_wb_en, exe_mem_r_en, exe_dest,
           mem_wb_en, mem_dest, fwd_en, branch_taken, mem_access, sram_ready,
    output if_freeze, if_flush, id_bubble, pipe_freeze, mem_err, stall_cycles
  );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational data-hazard comparator. With forwarding only a load feeding
// the next instruction stalls; without it any pending write-back does.
module hazard_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic     id_valid,
  input  logic     two_src,
  input  reg_idx_t src1,
  input  reg_idx_t src2,
  input  logic     exe_wb_en,
  input  logic     exe_mem_r_en,
  input  reg_idx_t exe_dest,
  input  logic     mem_wb_en,
  input  reg_idx_t mem_dest,
  input  logic     fwd_en,
  output logic     hazard
);

  logic exe_hit;
  logic mem_hit;

  // NOTE: every variable gets a default at the top of an always_comb so no
  // path can leave it unassigned, which would otherwise infer a latch.
  always_comb begin
    hazard  = 1'b0;
    exe_hit = writes_to(exe_wb_en, exe_dest, src1) ||
              (two_src && writes_to(exe_wb_en, exe_dest, src2));
    mem_hit = writes_to(mem_wb_en, mem_dest, src1) ||
              (two_src && writes_to(mem_wb_en, mem_dest, src2));
    if (id_valid) begin
      hazard = fwd_en ? (exe_mem_r_en && exe_hit) : (exe_hit || mem_hit);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: merges data hazards, taken branches and the
// SRAM wait/timeout FSM into one prioritised set of stage controls.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 1023,
  parameter int CNT_W       = 10
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic [STALL_W-1:0]  stall_cycles_q, stall_cycles_d;
  logic                hazard;
  logic                mem_stall;
  stage_ctrl_t         ctrl;

  hazard_detect u_hazard_detect (
    .id_valid     (bus.id_valid),
    .two_src      (bus.two_src),
    .src1         (bus.src1),
    .src2         (bus.src2),
    .exe_wb_en    (bus.exe_wb_en),
    .exe_mem_r_en (bus.exe_mem_r_en),
    .exe_dest     (bus.exe_dest),
    .mem_wb_en    (bus.mem_wb_en),
    .mem_dest     (bus.mem_dest),
    .fwd_en       (bus.fwd_en),
    .hazard       (hazard)
  );

  // The issue cycle of an access that is not ready already stalls, so the
  // freeze lines up with the access and drops in the ready cycle.
  always_comb begin : fsm_next
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_stall  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (bus.mem_access && !bus.sram_ready) begin
          state_d    = ST_WAIT;
          wait_cnt_d = '0;
          mem_stall  = 1'b1;
        end
      end
      ST_WAIT: begin
        mem_stall = !bus.sram_ready;
        if (bus.sram_ready) begin
          state_d = ST_RUN;
        end else if (wait_cnt_q == TIMEOUT_CNT) begin
          state_d = ST_ERR;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      ST_ERR: begin
        mem_stall = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Memory stall outranks branch, branch outranks hazard; the branch path
  // never freezes, so flush and freeze are mutually exclusive.
  always_comb begin : prio_mux
    ctrl = '0;
    if (mem_stall) begin
      ctrl.pipe_freeze = 1'b1;
      ctrl.if_freeze   = 1'b1;
    end else if (bus.branch_taken) begin
      ctrl.if_flush    = 1'b1;
      ctrl.id_bubble   = 1'b1;
    end else if (hazard) begin
      ctrl.if_freeze   = 1'b1;
      ctrl.id_bubble   = 1'b1;
    end
  end

  always_comb begin : stall_count
    stall_cycles_d = stall_cycles_q;
    if (ctrl.if_freeze && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample
  // pre-edge values; rst is in the sensitivity list to act without a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_RUN;
      wait_cnt_q     <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign bus.if_freeze    = ctrl.if_freeze;
  assign bus.if_flush     = ctrl.if_flush;
  assign bus.id_bubble    = ctrl.id_bubble;
  assign bus.pipe_freeze  = ctrl.pipe_freeze;
  assign bus.mem_err      = (state_q == ST_ERR);
  assign bus.stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus random
// stimulus compared every cycle against a behavioural reference model.
module tb_pipe_hazard_ctrl;

  localparam int TIMEOUT = 7;

  logic clk;
  logic rst;

  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl #(
    .MEM_TIMEOUT (TIMEOUT),
    .CNT_W       (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: outstanding-access flag, 1-based WAIT cycle index,
  // sticky error, and an unbounded stall count clipped on use.
  bit     m_busy;
  int     m_wait_idx;
  bit     m_err;
  longint m_stalls;

  bit e_if_freeze, e_if_flush, e_id_bubble, e_pipe_freeze;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_hazard();
    bit         h;
    logic [3:0] s;
    bit         exe_hit, mem_hit;
    int         n_src;
    h = 1'b0;
    if (!bus.id_valid) return 1'b0;
    n_src = bus.two_src ? 2 : 1;
    for (int i = 0; i < n_src; i++) begin
      s       = (i == 0) ? bus.src1 : bus.src2;
      exe_hit = bus.exe_wb_en && (bus.exe_dest == s);
      mem_hit = bus.mem_wb_en && (bus.mem_dest == s);
      if (bus.fwd_en) h = h | (exe_hit && bus.exe_mem_r_en);
      else            h = h | exe_hit | mem_hit;
    end
    return h;
  endfunction

  task automatic clear_inputs();
    bus.id_valid     = 1'b0;
    bus.two_src      = 1'b0;
    bus.src1         = '0;
    bus.src2         = '0;
    bus.exe_wb_en    = 1'b0;
    bus.exe_mem_r_en = 1'b0;
    bus.exe_dest     = '0;
    bus.mem_wb_en    = 1'b0;
    bus.mem_dest     = '0;
    bus.fwd_en       = 1'b0;
    bus.branch_taken = 1'b0;
    bus.mem_access   = 1'b0;
    bus.sram_ready   = 1'b0;
  endtask

  task automatic model_reset();
    m_busy     = 1'b0;
    m_wait_idx = 0;
    m_err      = 1'b0;
    m_stalls   = 0;
  endtask

  // Let inputs settle, predict this cycle's outputs and compare.
  task automatic settle();
    bit stall, haz;
    #1;
    haz   = model_hazard();
    stall = m_err || (m_busy ? !bus.sram_ready
                             : (bus.mem_access && !bus.sram_ready));
    e_pipe_freeze = stall;
    e_if_freeze   = stall || (!bus.branch_taken && haz);
    e_if_flush    = !stall && bus.branch_taken;
    e_id_bubble   = !stall && (bus.branch_taken || haz);
    check("if_freeze",    {31'd0, bus.if_freeze},   {31'd0, e_if_freeze});
    check("if_flush",     {31'd0, bus.if_flush},    {31'd0, e_if_flush});
    check("id_bubble",    {31'd0, bus.id_bubble},   {31'd0, e_id_bubble});
    check("pipe_freeze",  {31'd0, bus.pipe_freeze}, {31'd0, e_pipe_freeze});
    check("mem_err",      {31'd0, bus.mem_err},     {31'd0, m_err});
    check("stall_cycles", bus.stall_cycles,
          (m_stalls > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : m_stalls[31:0]);
  endtask

  // Advance one clock, updating the model with the inputs seen at the edge.
  task automatic tick();
    @(posedge clk);
    if (!m_err) begin
      if (!m_busy) begin
        if (bus.mem_access && !bus.sram_ready) begin
          m_busy     = 1'b1;
          m_wait_idx = 1;
        end
      end else if (bus.sram_ready) begin
        m_busy = 1'b0;
      end else if (m_wait_idx == TIMEOUT + 1) begin
        m_busy = 1'b0;
        m_err  = 1'b1;
      end else begin
        m_wait_idx++;
      end
    end
    if (e_if_freeze) m_stalls = m_stalls + 1;
    if (m_stalls > 64'hFFFF_FFFF) m_stalls = 64'hFFFF_FFFF;
    @(negedge clk);
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    settle();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drive_random();
    bus.id_valid     = 1'($urandom_range(0, 3) != 0);
    bus.two_src      = 1'($urandom_range(0, 1));
    bus.src1         = 4'($urandom_range(0, 3));
    bus.src2         = 4'($urandom_range(0, 3));
    bus.exe_wb_en    = 1'($urandom_range(0, 1));
    bus.exe_mem_r_en = 1'($urandom_range(0, 1));
    bus.exe_dest     = 4'($urandom_range(0, 3));
    bus.mem_wb_en    = 1'($urandom_range(0, 1));
    bus.mem_dest     = 4'($urandom_range(0, 3));
    bus.fwd_en       = 1'($urandom_range(0, 1));
    bus.branch_taken = 1'($urandom_range(0, 4) == 0);
    bus.mem_access   = 1'($urandom_range(0, 3) == 0);
    bus.sram_ready   = 1'($urandom_range(0, 3) != 0);
  endtask

  initial begin
    int freeze_n;
    int flush_n;

    rst = 1'b1;
    clear_inputs();
    model_reset();
    do_reset();

    // Load-use hazard with forwarding, then the same without a load.
    bus.id_valid = 1'b1; bus.fwd_en = 1'b1; bus.exe_mem_r_en = 1'b1;
    bus.exe_wb_en = 1'b1; bus.exe_dest = 4'd3; bus.src1 = 4'd3;
    settle();
    check("load_use_freeze", {31'd0, bus.if_freeze}, 32'd1);
    check("load_use_bubble", {31'd0, bus.id_bubble}, 32'd1);
    tick();
    bus.exe_mem_r_en = 1'b0;
    settle();
    check("fwd_no_load_outs",
          {28'd0, bus.if_freeze, bus.if_flush, bus.id_bubble, bus.pipe_freeze}, 32'd0);
    tick();

    // Branch beats hazard.
    bus.exe_mem_r_en = 1'b1; bus.branch_taken = 1'b1;
    settle();
    check("branch_flush",  {31'd0, bus.if_flush},  32'd1);
    check("branch_freeze", {31'd0, bus.if_freeze}, 32'd0);
    tick();

    // No-forwarding hazard on src2 through MEM.
    clear_inputs();
    bus.id_valid = 1'b1; bus.mem_wb_en = 1'b1; bus.mem_dest = 4'd5;
    bus.two_src = 1'b1; bus.src2 = 4'd5; bus.src1 = 4'd0;
    settle();
    check("nofwd_src2_freeze", {31'd0, bus.if_freeze}, 32'd1);
    tick();
    bus.two_src = 1'b0;
    settle();
    check("nofwd_one_src_freeze", {31'd0, bus.if_freeze}, 32'd0);
    tick();

    // SRAM wait: ready on the 5th cycle after issue, branch held meanwhile.
    do_reset();
    freeze_n = 0;
    flush_n  = 0;
    bus.mem_access = 1'b1;
    for (int c = 0; c < 5; c++) begin
      bus.branch_taken = (c >= 2);
      settle();
      freeze_n += int'(bus.pipe_freeze);
      flush_n  += int'(bus.if_flush);
      tick();
    end
    check("sram_freeze_cycles", freeze_n, 32'd5);
    check("sram_flush_held",    flush_n,  32'd0);
    bus.sram_ready = 1'b1;
    settle();
    check("sram_release_freeze", {31'd0, bus.pipe_freeze}, 32'd0);
    check("sram_release_flush",  {31'd0, bus.if_flush},    32'd1);
    tick();
    clear_inputs();
    settle();
    check("sram_stall_count", bus.stall_cycles, 32'd5);
    tick();

    // Timeout: issue cycle plus eight WAIT cycles without ready reach ERR.
    do_reset();
    bus.mem_access = 1'b1;
    for (int c = 0; c <= TIMEOUT + 1; c++) begin
      settle();
      tick();
    end
    clear_inputs();
    bus.sram_ready = 1'b1;
    settle();
    check("err_mem_err", {31'd0, bus.mem_err},     32'd1);
    check("err_freeze",  {31'd0, bus.pipe_freeze}, 32'd1);
    tick();
    rst = 1'b1;
    model_reset();
    #1;
    check("async_rst_mem_err", {31'd0, bus.mem_err},     32'd0);
    check("async_rst_freeze",  {31'd0, bus.pipe_freeze}, 32'd0);
    check("async_rst_stalls",  bus.stall_cycles,         32'd0);
    #1;
    rst = 1'b0;
    @(negedge clk);

    // Counter saturation from a preloaded near-full value.
    force dut.stall_cycles_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cycles_q;
    m_stalls = 64'hFFFF_FFFE;
    bus.id_valid = 1'b1; bus.exe_wb_en = 1'b1; bus.exe_dest = 4'd2; bus.src1 = 4'd2;
    for (int c = 0; c < 3; c++) begin
      settle();
      tick();
    end
    clear_inputs();
    settle();
    check("stall_saturated", bus.stall_cycles, 32'hFFFF_FFFF);
    tick();

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      drive_random();
      settle();
      check("flush_and_freeze", {31'd0, bus.if_flush & bus.if_freeze}, 32'd0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
